alu_cmd_issuer: RTL
===================

// Module: alu_cmd_issuer
// PURPOSE
//  Initiator side of the sequential ALU operand/result interface. Accepts ALU
//  commands on a valid/ready port and buffers them in a DEPTH-entry FIFO.
//  Issues one command at a time on a_o/b_o/sel_o to the registered ALU
//  (1-cycle latency), captures y_i, and returns it on a valid/ready result port.
//  Sits between a command source (bench or controller) and the ALU instance.
// PARAMETERS
//  DW     4  operand/result width; must match the ALU
//  DEPTH  4  command FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1           clock, rising edge
//  reset      in   1           asynchronous, active-high reset
//  cmd_valid  in   1           command present
//  cmd_ready  out  1           FIFO can accept a command
//  cmd_a      in   DW          operand A
//  cmd_b      in   DW          operand B
//  cmd_sel    in   3           opcode: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 not-a, 110 or, 111 xor
//  a_o        out  DW          operand A to the ALU
//  b_o        out  DW          operand B to the ALU
//  sel_o      out  3           opcode to the ALU
//  y_i        in   DW          registered ALU result
//  res_valid  out  1           result present
//  res_ready  in   1           result consumer accepts
//  res_data   out  DW          captured result
//  res_sel    out  3           opcode that produced res_data
//  busy       out  1           FIFO non-empty or FSM not in IDLE
//  op_count   out  8           completed results; wraps 255->0
//  chk_err    out  1           sticky mismatch flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0. FIFO empty. FSM in IDLE. cmd_ready goes to 1 on the first edge after reset deasserts.
//  Reset mid-operation: in-flight and queued commands are discarded; res_valid drops asynchronously.
//  cmd_ready = !full, from registered count. No same-cycle bypass: a pop does not raise cmd_ready until the next cycle.
//  Push on edge with cmd_valid&&cmd_ready. The FIFO preserves command order.
//  FSM states:
//   IDLE: if FIFO not empty, pop head into a_o/b_o/sel_o, go to ISSUE.
//   ISSUE: the ALU samples the operands on this edge. Go to CAPT.
//   CAPT: res_data<=y_i, res_sel<=sel_o, res_valid<=1. Go to RESP.
//   RESP: hold res_data/res_sel stable while res_valid&&!res_ready. On the handshake: res_valid<=0, op_count++, go to IDLE.
//  a_o/b_o/sel_o hold their last issued values until the next pop; they never glitch.
//  Latency: command accepted on edge E -> res_valid rises at E+3 (FIFO previously empty, FSM in IDLE).
//  Throughput: 1 result per 4 cycles with res_ready tied high.
//  Back-pressure: res_ready low stalls the FSM in RESP. The FIFO keeps filling until full.
//  ALU semantics (used by the checker and the bench):
//   add/sub: mod 2^DW.
//   mul: low DW bits.
//   div: b==0 gives 0.
//   not: ~a; b is ignored.
// CONFIGURATION
//  ALU_ISSUER_CHECK_EN defined:
//   - In CAPT, compute the expected value from a_o/b_o/sel_o using the ALU semantics.
//   - If y_i !== expected, set chk_err=1. It stays set until reset.
//  ALU_ISSUER_CHECK_EN undefined: chk_err tied 0 and the model is not built.
// TESTING
//  T1 single op: a=4,b=3,sel=000 accepted at edge E -> res_valid at E+3, res_data=7, res_sel=000, op_count=1.
//  T2 wrap/trunc: (7,9,001)->14, (3,6,010)->2, (15,1,000)->0; results in order.
//  T3 div by zero: (9,0,011)->0. Also (8,2,011)->4 and (10,x,101)->5.
//  T4 full/back-pressure: res_ready=0, push 6 cmds -> 1 held in RESP, DEPTH queued, cmd_ready=0.
//     Then res_ready=1 -> all results drain in order and op_count increments by 6.
//  T5 reset mid-op: assert reset while in ISSUE with 2 queued -> outputs 0 at once.
//     No res_valid after release; a new cmd completes normally.
//  T6 (CHECK_EN): ALU model forces y_i=0 on xor (12,10) -> chk_err=1 and stays 1.
//     Without the macro, chk_err=0.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - queues ALU commands, issues them to a registered ALU, returns results.
// Optional result checker enabled by defining ALU_ISSUER_CHECK_EN.
module alu_cmd_issuer #(
    parameter int DW    = 4,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_a,
    input  logic [DW-1:0] cmd_b,
    input  logic [2:0]    cmd_sel,
    output logic [DW-1:0] a_o,
    output logic [DW-1:0] b_o,
    output logic [2:0]    sel_o,
    input  logic [DW-1:0] y_i,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic [2:0]    res_sel,
    output logic          busy,
    output logic [7:0]    op_count,
    output logic          chk_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

    state_t          state, state_n;
    logic [DW-1:0]   fifo_a   [DEPTH];
    logic [DW-1:0]   fifo_b   [DEPTH];
    logic [2:0]      fifo_sel [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count, count_n;
    logic            push, pop, capture, done;

    assign push = cmd_valid && cmd_ready;
    assign busy = (count != '0) || (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        capture = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: state_n = CAPT;
            CAPT: begin
                capture = 1'b1;
                state_n = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_n = count + (AW+1)'(1);
            2'b01:   count_n = count - (AW+1)'(1);
            default: count_n = count;
        endcase
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr]   <= cmd_a;
            fifo_b[wr_ptr]   <= cmd_b;
            fifo_sel[wr_ptr] <= cmd_sel;
        end
    end

    // cmd_ready comes from the next count so a pop only frees a slot one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_n;
            cmd_ready <= (count_n != (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_o       <= '0;
            b_o       <= '0;
            sel_o     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sel   <= '0;
            op_count  <= '0;
        end else begin
            if (pop) begin
                a_o   <= fifo_a[rd_ptr];
                b_o   <= fifo_b[rd_ptr];
                sel_o <= fifo_sel[rd_ptr];
            end
            if (capture) begin
                res_data  <= y_i;
                res_sel   <= sel_o;
                res_valid <= 1'b1;
            end
            if (done) begin
                res_valid <= 1'b0;
                op_count  <= op_count + 8'd1;
            end
        end
    end

`ifdef ALU_ISSUER_CHECK_EN
    function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [2:0] sel);
        case (sel)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a * b;
            3'b011:  return (b == '0) ? '0 : a / b;
            3'b100:  return a & b;
            3'b101:  return ~a;
            3'b110:  return a | b;
            default: return a ^ b;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                          chk_err <= 1'b0;
        else if (capture && (y_i !== alu_ref(a_o, b_o, sel_o))) chk_err <= 1'b1;
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule
